// File: rtl/arch_map_table_if.sv
// Retire/recovery bus between the commit stage and the architectural map table.
// The table side uses the slave modport; the retire logic uses master.
interface arch_map_table_if #(
    parameter int LOG_ARCH = 6,
    parameter int PHYS_LOG = 7
);
    logic [3:0]          commitValid_i;
    logic [LOG_ARCH-1:0] commitLogDest_i [4];
    logic [PHYS_LOG-1:0] commitPhyDest_i [4];
    logic                recoverFlag_i;

    logic [3:0]          freeValid_o;
    logic [PHYS_LOG-1:0] freeReg_o [4];
    logic                recoverValid_o;
    logic [LOG_ARCH-1:0] recoverBase_o;
    logic [3:0]          recoverLaneValid_o;
    logic [PHYS_LOG-1:0] recoverPhys_o [4];
    logic                recoverDone_o;
    logic                busy_o;

    modport master (
        output commitValid_i, commitLogDest_i, commitPhyDest_i, recoverFlag_i,
        input  freeValid_o, freeReg_o, recoverValid_o, recoverBase_o,
               recoverLaneValid_o, recoverPhys_o, recoverDone_o, busy_o
    );

    modport slave (
        input  commitValid_i, commitLogDest_i, commitPhyDest_i, recoverFlag_i,
        output freeValid_o, freeReg_o, recoverValid_o, recoverBase_o,
               recoverLaneValid_o, recoverPhys_o, recoverDone_o, busy_o
    );
endinterface

// File: rtl/arch_map_table.sv
// Committed logical-to-physical map: releases superseded physical registers on
// retire and streams the whole map out four entries per beat on recovery.
module arch_map_table #(
    parameter int NUM_ARCH = 34,
    parameter int LOG_ARCH = 6,
    parameter int PHYS_LOG = 7
) (
    input  logic            clk,
    input  logic            reset,
    arch_map_table_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_e;

    localparam logic [3:0]          LAST_BEAT  = 4'((NUM_ARCH + 3) / 4 - 1);
    localparam logic [LOG_ARCH-1:0] NUM_ARCH_W = LOG_ARCH'(NUM_ARCH);

    state_e              state_q, state_d;
    logic [3:0]          beat_q, beat_d;
    logic [PHYS_LOG-1:0] table_q [NUM_ARCH];
    logic [PHYS_LOG-1:0] table_d [NUM_ARCH];
    logic [PHYS_LOG-1:0] old_phys [4];
    logic                commit_en;

    logic [3:0]          free_valid_q, free_valid_d;
    logic [PHYS_LOG-1:0] free_reg_q [4];
    logic [PHYS_LOG-1:0] free_reg_d [4];
    logic                rec_valid_q, rec_valid_d;
    logic [LOG_ARCH-1:0] rec_base_q, rec_base_d;
    logic [3:0]          rec_lane_valid_q, rec_lane_valid_d;
    logic [PHYS_LOG-1:0] rec_phys_q [4];
    logic [PHYS_LOG-1:0] rec_phys_d [4];
    logic                rec_done_q, rec_done_d;
    logic [LOG_ARCH-1:0] lane_idx;

    // Commit path: an older slot in the same bundle that targets the same
    // register supplies the old mapping instead of the table.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        commit_en = (state_q == IDLE);
        table_d   = table_q;
        for (int k = 0; k < 4; k++) begin
            old_phys[k] = table_q[bus.commitLogDest_i[k]];
            for (int j = 0; j < k; j++) begin
                if (bus.commitValid_i[j] && bus.commitLogDest_i[j] == bus.commitLogDest_i[k])
                    old_phys[k] = bus.commitPhyDest_i[j];
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (commit_en && bus.commitValid_i[k])
                table_d[bus.commitLogDest_i[k]] = bus.commitPhyDest_i[k];
            free_valid_d[k] = commit_en & bus.commitValid_i[k];
            free_reg_d[k]   = free_valid_d[k] ? old_phys[k] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (bus.recoverFlag_i) begin
                    state_d = STREAM;
                    beat_d  = '0;
                end
            end
            STREAM: begin
                if (bus.recoverFlag_i) begin
                    beat_d = '0;
                end else if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs are computed from next state and post-commit table so they
    // appear registered in the cycle the beat belongs to.
    always_comb begin
        rec_valid_d = (state_d == STREAM);
        rec_base_d  = rec_valid_d ? LOG_ARCH'({beat_d, 2'b00}) : '0;
        rec_done_d  = rec_valid_d && (beat_d == LAST_BEAT);
        lane_idx    = '0;
        for (int l = 0; l < 4; l++) begin
            lane_idx            = rec_base_d + LOG_ARCH'(l);
            rec_lane_valid_d[l] = rec_valid_d && (lane_idx < NUM_ARCH_W);
            rec_phys_d[l]       = rec_lane_valid_d[l] ? table_d[lane_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q          <= IDLE;
            beat_q           <= '0;
            free_valid_q     <= '0;
            rec_valid_q      <= 1'b0;
            rec_base_q       <= '0;
            rec_lane_valid_q <= '0;
            rec_done_q       <= 1'b0;
            // NOTE: the map is a small flop array whose identity contents are architectural, so it is reset.
            for (int i = 0; i < NUM_ARCH; i++) table_q[i] <= PHYS_LOG'(i);
            for (int k = 0; k < 4; k++) begin
                free_reg_q[k] <= '0;
                rec_phys_q[k] <= '0;
            end
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            table_q          <= table_d;
            free_valid_q     <= free_valid_d;
            free_reg_q       <= free_reg_d;
            rec_valid_q      <= rec_valid_d;
            rec_base_q       <= rec_base_d;
            rec_lane_valid_q <= rec_lane_valid_d;
            rec_phys_q       <= rec_phys_d;
            rec_done_q       <= rec_done_d;
        end
    end

    assign bus.busy_o             = (state_q == STREAM);
    assign bus.freeValid_o        = free_valid_q;
    assign bus.freeReg_o          = free_reg_q;
    assign bus.recoverValid_o     = rec_valid_q;
    assign bus.recoverBase_o      = rec_base_q;
    assign bus.recoverLaneValid_o = rec_lane_valid_q;
    assign bus.recoverPhys_o      = rec_phys_q;
    assign bus.recoverDone_o      = rec_done_q;

    for (genvar k = 0; k < 4; k++) begin : g_dest_chk
        a_log_dest_range: assert property (@(posedge clk) disable iff (reset)
            bus.commitValid_i[k] |-> bus.commitLogDest_i[k] < NUM_ARCH_W);
    end
endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table: table-driven commit vectors followed by
// hand-written recovery, abort/restart and mid-stream reset sequences.
module tb_arch_map_table;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [6:0] exp_tab [34];

    always #5 clk = ~clk;

    arch_map_table_if bus ();

    arch_map_table dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] valid;
        logic [5:0] log_dest [4];
        logic [6:0] phy_dest [4];
        logic [3:0] exp_fv;
        logic [6:0] exp_fr [4];
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.commitValid_i = '0;
        bus.recoverFlag_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.commitLogDest_i[k] = '0;
            bus.commitPhyDest_i[k] = '0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},   32'(bus.busy_o), 0);
        check({tag, " rvalid"}, 32'(bus.recoverValid_o), 0);
        check({tag, " done"},   32'(bus.recoverDone_o), 0);
    endtask

    task automatic check_beat(input string tag, input int b, input bit done_exp);
        int idx;
        check($sformatf("%s b%0d rvalid", tag, b), 32'(bus.recoverValid_o), 1);
        check($sformatf("%s b%0d busy", tag, b),   32'(bus.busy_o), 1);
        check($sformatf("%s b%0d base", tag, b),   32'(bus.recoverBase_o), 32'(4 * b));
        check($sformatf("%s b%0d done", tag, b),   32'(bus.recoverDone_o), 32'(done_exp));
        for (int l = 0; l < 4; l++) begin
            idx = 4 * b + l;
            check($sformatf("%s b%0d lv%0d", tag, b, l), 32'(bus.recoverLaneValid_o[l]),
                  (idx < 34) ? 1 : 0);
            check($sformatf("%s b%0d ph%0d", tag, b, l), 32'(bus.recoverPhys_o[l]),
                  (idx < 34) ? 32'(exp_tab[idx]) : 0);
        end
    endtask

    initial begin
        // Expected free results are worked out by hand from an identity table.
        vecs[0] = '{4'b0001, '{5, 0, 0, 0},   '{40, 0, 0, 0},   4'b0001, '{5, 0, 0, 0}};
        vecs[1] = '{4'b0101, '{7, 0, 7, 0},   '{50, 0, 51, 0},  4'b0101, '{7, 0, 50, 0}};
        vecs[2] = '{4'b1111, '{1, 2, 3, 4},   '{60, 61, 62, 63}, 4'b1111, '{1, 2, 3, 4}};
        vecs[3] = '{4'b0001, '{1, 0, 0, 0},   '{64, 0, 0, 0},   4'b0001, '{60, 0, 0, 0}};
        vecs[4] = '{4'b1110, '{0, 5, 5, 5},   '{0, 41, 43, 42}, 4'b1110, '{0, 40, 41, 43}};
        vecs[5] = '{4'b1000, '{0, 0, 0, 7},   '{0, 0, 0, 52},   4'b1000, '{0, 0, 0, 51}};
        vecs[6] = '{4'b0000, '{9, 9, 9, 9},   '{99, 98, 97, 96}, 4'b0000, '{0, 0, 0, 0}};
        vecs[7] = '{4'b1111, '{0, 33, 31, 0}, '{10, 11, 12, 13}, 4'b1111, '{0, 33, 31, 10}};
        vecs[8] = '{4'b0010, '{0, 33, 0, 0},  '{0, 20, 0, 0},   4'b0010, '{0, 11, 0, 0}};

        reset = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset fv", 32'(bus.freeValid_o), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.commitValid_i = vecs[i].valid;
            for (int k = 0; k < 4; k++) begin
                bus.commitLogDest_i[k] = vecs[i].log_dest[k];
                bus.commitPhyDest_i[k] = vecs[i].phy_dest[k];
            end
            @(negedge clk);
            clear_inputs();
            check($sformatf("v%0d fv", i), 32'(bus.freeValid_o), 32'(vecs[i].exp_fv));
            for (int k = 0; k < 4; k++)
                check($sformatf("v%0d fr%0d", i, k), 32'(bus.freeReg_o[k]), 32'(vecs[i].exp_fr[k]));
        end

        // Committed map after the vectors above plus the commit issued with recovery.
        for (int i = 0; i < 34; i++) exp_tab[i] = 7'(i);
        exp_tab[0] = 13; exp_tab[1] = 64; exp_tab[2] = 61; exp_tab[3] = 62;
        exp_tab[4] = 63; exp_tab[5] = 42; exp_tab[7] = 52; exp_tab[31] = 12;
        exp_tab[33] = 70;

        // Recovery with a same-edge commit: the stream must show the new mapping.
        bus.commitValid_i      = 4'b0001;
        bus.commitLogDest_i[0] = 33;
        bus.commitPhyDest_i[0] = 70;
        bus.recoverFlag_i      = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("rec1 fv", 32'(bus.freeValid_o), 1);
        check("rec1 fr0", 32'(bus.freeReg_o[0]), 20);
        for (int b = 0; b < 9; b++) begin
            check_beat("rec1", b, b == 8);
            if (b == 1) check("rec1 fv quiet", 32'(bus.freeValid_o), 0);
            @(negedge clk);
        end
        check_idle("rec1 end");

        // Commit during beat 3 is ignored; flag at beat 5 restarts without done.
        bus.recoverFlag_i = 1'b1;
        @(negedge clk);
        bus.recoverFlag_i = 1'b0;
        for (int b = 0; b < 6; b++) begin
            check_beat("abort", b, 1'b0);
            if (b == 3) begin
                bus.commitValid_i      = 4'b0001;
                bus.commitLogDest_i[0] = 9;
                bus.commitPhyDest_i[0] = 90;
            end
            if (b == 4) begin
                check("busy commit fv", 32'(bus.freeValid_o), 0);
                clear_inputs();
            end
            if (b == 5) bus.recoverFlag_i = 1'b1;
            @(negedge clk);
        end
        bus.recoverFlag_i = 1'b0;
        for (int b = 0; b < 9; b++) begin
            check_beat("restart", b, b == 8);
            @(negedge clk);
        end
        check_idle("restart end");

        // Reset at beat 4, then a fresh stream must show identity.
        bus.recoverFlag_i = 1'b1;
        @(negedge clk);
        bus.recoverFlag_i = 1'b0;
        repeat (4) @(negedge clk);
        check_beat("prereset", 4, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        check("midreset fv", 32'(bus.freeValid_o), 0);
        reset = 1'b0;
        for (int i = 0; i < 34; i++) exp_tab[i] = 7'(i);
        bus.recoverFlag_i = 1'b1;
        @(negedge clk);
        bus.recoverFlag_i = 1'b0;
        for (int b = 0; b < 9; b++) begin
            check_beat("ident", b, b == 8);
            @(negedge clk);
        end
        check_idle("ident end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arch_map_table.md
Name: arch_map_table

Overview:
- Architectural (committed) register map table in the rename/retire path. It sits directly upstream of the speculative free list.
- On each retire bundle it records the new logical-to-physical mapping. It releases the previously committed physical register of each retiring destination to the free list.
- On pipeline recovery it streams the committed map out, four entries per cycle, so the speculative rename map table can be rebuilt.

Parameters:
- NUM_ARCH, 34, number of logical registers (32 GPR + HI + LO).
- LOG_ARCH, 6, width of a logical register index.
- PHYS_LOG, 7, width of a physical register index (equals SIZE_PHYSICAL_LOG).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commitValid{0..3}_i  in  1 each  slot k retires an instruction with a destination; slot 0 is oldest
- commitLogDest{0..3}_i  in  LOG_ARCH each  logical destination of slot k
- commitPhyDest{0..3}_i  in  PHYS_LOG each  new physical destination of slot k
- recoverFlag_i  in  1  start recovery readout (single-cycle pulse)
- freeValid{0..3}_o  out  1 each  physical register released by slot k; drives free list commitValid{k}
- freeReg{0..3}_o  out  PHYS_LOG each  released physical register; drives free list commitReg{k}
- recoverValid_o  out  1  recovery beat valid
- recoverBase_o  out  LOG_ARCH  logical index of lane 0 in the current beat
- recoverLaneValid{0..3}_o  out  1 each  lane carries a real entry (recoverBase_o+lane < NUM_ARCH)
- recoverPhys{0..3}_o  out  PHYS_LOG each  committed mapping of logical recoverBase_o+lane
- recoverDone_o  out  1  one-cycle pulse, coincident with the last beat
- busy_o  out  1  high while recovery streaming is in progress

Behaviour:
- Storage: NUM_ARCH x PHYS_LOG flops.
  - On reset, entry i = i.
  - All outputs reset to 0. The FSM resets to IDLE.
- Commit, applied on the clk edge when busy_o=0:
  - Slot k old mapping: use commitPhyDest_j of the highest j<k with commitValid_j=1 and commitLogDest_j==commitLogDest_k. If no such j exists, use table[commitLogDest_k] before the edge.
  - Table write: for each logical register, the highest valid slot targeting it wins.
  - Lower slots targeting the same register do not write, but still release their old mapping as defined above.
- Free outputs are registered, with one-cycle latency.
  - freeValid_k(T+1) = commitValid_k(T) & ~busy_o(T).
  - freeReg_k(T+1) = old mapping of slot k. freeReg_k is 0 when freeValid_k is 0.
  - Lanes are not compacted: any valid pattern 0..15 may appear.
- Commits while busy_o=1 are ignored: no table write and no free. Upstream holds retirement while busy_o=1.
- Recovery FSM, two states IDLE and STREAM:
  - IDLE -> STREAM when recoverFlag_i is sampled at edge T. Commits at T are applied first; the stream reflects the post-T table.
  - Beat b (b=0..8) is emitted in cycle T+1+b with recoverValid_o=1 and recoverBase_o=4b. Outputs are registered.
  - In beat 8 only lane 0 and lane 1 are valid (logical 32, 33). Lanes 2 and 3 have LaneValid=0 and Phys=0.
  - recoverDone_o=1 in beat 8, then the FSM returns to IDLE.
  - busy_o=1 from T+1 through beat 8 inclusive.
- recoverFlag_i during STREAM restarts from beat 0 on the next cycle, with no recoverDone_o for the aborted stream.
- Reset mid-stream: FSM goes to IDLE, the table returns to identity, and all outputs go to 0 on the next cycle.
- Index arithmetic is LOG_ARCH bits; the beat counter is 4 bits.
- commitLogDest >= NUM_ARCH is illegal. A simulation assertion flags it; the RTL result is don't-care.

Test Plan:
- Reset, then slot0 commits log 5 -> phys 40 → next cycle freeValid0=1, freeReg0=5; table[5]=40.
- Same bundle: slot0 log 7 -> 50, slot2 log 7 -> 51 → freeReg0=7, freeReg2=50, freeValid1/3=0; table[7]=51.
- All four slots commit distinct logs 1..4 -> phys 60..63 → freeReg0..3 = 1..4; a following bundle committing log 1 -> 64 frees 60.
- Commit log 33 -> 70 in the same cycle as recoverFlag_i → 9 beats, busy_o high 9 cycles; beat 8 recoverBase_o=32, Phys0=32, Phys1=70, LaneValid2/3=0, recoverDone_o=1.
- Commit presented during beat 3 → no freeValid and table unchanged. recoverFlag_i at beat 5 → stream restarts at base 0, with no done pulse for the first stream.
- Reset asserted at beat 4 → busy_o=0 and recoverValid_o=0 the next cycle; the subsequent recovery stream shows identity mapping.
